// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the pipeline sequencer.
interface pipe_ctrl_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        pc_jump_en_o;
  logic [31:0] pc_jump_addr_o;
  logic        stall_pc_o;
  logic        stall_if_id_o;
  logic        stall_id_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        wdt_fault_o;

  // Datapath side: raises requests, consumes stall/flush/redirect controls.
  modport master (
    output jump_en_i, jump_addr_i, hold_ex_i, mem_req_i, mem_ack_i,
           ex_is_load_i, ex_rd_i, id_rs1_i, id_rs2_i,
    input  pc_jump_en_o, pc_jump_addr_o, stall_pc_o, stall_if_id_o,
           stall_id_ex_o, flush_if_id_o, flush_id_ex_o, wdt_fault_o
  );

  // Sequencer side.
  modport slave (
    input  jump_en_i, jump_addr_i, hold_ex_i, mem_req_i, mem_ack_i,
           ex_is_load_i, ex_rd_i, id_rs1_i, id_rs2_i,
    output pc_jump_en_o, pc_jump_addr_o, stall_pc_o, stall_if_id_o,
           stall_id_ex_o, flush_if_id_o, flush_id_ex_o, wdt_fault_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the IF/ID/EX core: merges EX redirect, EX hold and
// data-bus wait into per-stage stall/flush controls, inserts load-use bubbles
// and watchdogs stuck stalls. Controls are combinational from state + inputs.
module pipe_ctrl #(
  parameter int unsigned FLUSH_LEN = 1,
  parameter int unsigned WDT_LIMIT = 256,
  parameter int unsigned CNT_W     = 9
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned FL_W   = 4;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t              state;
  logic                pend_v;
  logic [ADDR_W-1:0]   pend_addr;
  logic [CNT_W-1:0]    wdt_cnt;
  logic [FL_W-1:0]     fl_cnt;

  logic                stall_src;
  logic                load_use;
  logic [CNT_W-1:0]    wdt_nxt;
  logic                wdt_hit;
  logic [ADDR_W-1:0]   redir_addr;

  logic                pc_jump_en;
  logic [ADDR_W-1:0]   pc_jump_addr;
  logic                stall_pc;
  logic                stall_if_id;
  logic                stall_id_ex;
  logic                flush_if_id;
  logic                flush_id_ex;
  logic                wdt_fault;

  // Stall source, load-use hazard, saturating watchdog step, redirect target.
  always_comb begin
    stall_src  = bus.hold_ex_i | (bus.mem_req_i & ~bus.mem_ack_i);
    load_use   = bus.ex_is_load_i && (bus.ex_rd_i != 5'd0) &&
                 ((bus.ex_rd_i == bus.id_rs1_i) || (bus.ex_rd_i == bus.id_rs2_i));
    wdt_nxt    = (wdt_cnt == {CNT_W{1'b1}}) ? wdt_cnt : wdt_cnt + CNT_W'(1);
    wdt_hit    = (WDT_LIMIT != 0) && (32'(wdt_nxt) >= WDT_LIMIT);
    redir_addr = pend_v ? pend_addr : bus.jump_addr_i;
  end

  // Control outputs; forced low while reset is asserted.
  always_comb begin
    pc_jump_en   = 1'b0;
    pc_jump_addr = '0;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    wdt_fault    = 1'b0;
    if (rst_n) begin
      unique case (state)
        ST_RUN: begin
          if (stall_src) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
          end else if (bus.jump_en_i) begin
            pc_jump_en   = 1'b1;
            pc_jump_addr = bus.jump_addr_i;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
        ST_STALL: begin
          if (stall_src) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
          end else if (pend_v || bus.jump_en_i) begin
            pc_jump_en   = 1'b1;
            pc_jump_addr = redir_addr;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
          end
        end
        ST_FLUSH: begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (stall_src) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
          end
        end
        ST_FAULT: begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          stall_id_ex = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          wdt_fault   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_jump_en_o   = pc_jump_en;
  assign bus.pc_jump_addr_o = pc_jump_addr;
  assign bus.stall_pc_o     = stall_pc;
  assign bus.stall_if_id_o  = stall_if_id;
  assign bus.stall_id_ex_o  = stall_id_ex;
  assign bus.flush_if_id_o  = flush_if_id;
  assign bus.flush_id_ex_o  = flush_id_ex;
  assign bus.wdt_fault_o    = wdt_fault;

  // Sequencer state: mode, pending redirect, watchdog and flush counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      wdt_cnt   <= '0;
      fl_cnt    <= '0;
    end else begin
      wdt_cnt <= stall_src ? wdt_nxt : '0;
      unique case (state)
        ST_RUN: begin
          if (stall_src) begin
            if (bus.jump_en_i) begin
              pend_v    <= 1'b1;
              pend_addr <= bus.jump_addr_i;
            end
            state <= wdt_hit ? ST_FAULT : ST_STALL;
          end else if (bus.jump_en_i && (FLUSH_LEN > 1)) begin
            state  <= ST_FLUSH;
            fl_cnt <= FL_W'(FLUSH_LEN - 1);
          end
        end
        ST_STALL: begin
          if (stall_src) begin
            if (bus.jump_en_i && !pend_v) begin
              pend_v    <= 1'b1;
              pend_addr <= bus.jump_addr_i;
            end
            if (wdt_hit) state <= ST_FAULT;
          end else if ((pend_v || bus.jump_en_i) && (FLUSH_LEN > 1)) begin
            pend_v <= 1'b0;
            state  <= ST_FLUSH;
            fl_cnt <= FL_W'(FLUSH_LEN - 1);
          end else begin
            pend_v <= 1'b0;
            state  <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (stall_src) begin
            if (wdt_hit) state <= ST_FAULT;
          end else begin
            fl_cnt <= fl_cnt - FL_W'(1);
            if (fl_cnt <= FL_W'(1)) state <= ST_RUN;
          end
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_RUN;
      endcase
    end
  end

endmodule
